tap_addr_gen: RTL and testbench

Tap address generator for the upsampler datapath. Sits directly downstream of the controller's instruction fetch stage. On a start pulse it latches the fetched ring-segment pointers (`data_lptr`, `data_uptr`) and coefficient pointer (`coef_ptr`), then walks one data address and one coefficient address per cycle so the MAC can compute one vector. Data addresses descend from the newest sample and wrap inside the segment.

---
 rtl/tap_addr_gen_if.sv | 34 +++
 rtl/tap_addr_gen.sv | 143 ++++++++++++++
 tb/tb_tap_addr_gen.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/tap_addr_gen_if.sv
// Instruction-field and tap-address bus between the fetch stage / MAC and the
// tap address generator.
interface tap_addr_gen_if #(
    parameter int DAWIDTH  = 12,
    parameter int VIDWIDTH = 5
);
    logic                start;
    logic                hold;
    logic [DAWIDTH-1:0]  data_lptr;
    logic [DAWIDTH-1:0]  data_uptr;
    logic [DAWIDTH-1:0]  data_head;
    logic [DAWIDTH-1:0]  coef_ptr;
    logic [VIDWIDTH-1:0] vector_id;

    logic                rd_en;
    logic [DAWIDTH-1:0]  data_addr;
    logic [DAWIDTH-1:0]  coef_addr;
    logic                acc_clr;
    logic                acc_last;
    logic [VIDWIDTH-1:0] vid_out;
    logic                busy;
    logic                done;
    logic                err;

    modport master (
        output start, hold, data_lptr, data_uptr, data_head, coef_ptr, vector_id,
        input  rd_en, data_addr, coef_addr, acc_clr, acc_last, vid_out, busy, done, err
    );

    modport slave (
        input  start, hold, data_lptr, data_uptr, data_head, coef_ptr, vector_id,
        output rd_en, data_addr, coef_addr, acc_clr, acc_last, vid_out, busy, done, err
    );
endinterface

// File: rtl/tap_addr_gen.sv
// Tap address generator: walks one descending, segment-wrapping data address and
// one ascending coefficient address per cycle for a single MAC vector.
module tap_addr_gen #(
    parameter int DAWIDTH  = 12,
    parameter int VIDWIDTH = 5
) (
    input logic           clk,
    input logic           rst,
    tap_addr_gen_if.slave bus
);
    localparam int CW = DAWIDTH + 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t              state, state_nx;
    logic [DAWIDTH-1:0]  lptr_q, lptr_nx;
    logic [DAWIDTH-1:0]  uptr_q, uptr_nx;
    logic [DAWIDTH-1:0]  daddr_q, daddr_nx;
    logic [DAWIDTH-1:0]  caddr_q, caddr_nx;
    logic [CW-1:0]       remain_q, remain_nx;
    logic [VIDWIDTH-1:0] vid_q, vid_nx;
    logic                rd_en_q, rd_en_nx;
    logic                clr_q, clr_nx;
    logic                last_q, last_nx;
    logic                busy_q, busy_nx;
    logic                done_q, done_nx;
    logic                err_q, err_nx;
    logic                start_ok;

    assign start_ok = (bus.data_lptr <= bus.data_uptr) &&
                      (bus.data_head >= bus.data_lptr) &&
                      (bus.data_head <= bus.data_uptr);

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_nx;
    end

    always_comb begin
        // NOTE: every next value defaults to the held value first, so no latch can form.
        state_nx  = state;
        lptr_nx   = lptr_q;
        uptr_nx   = uptr_q;
        daddr_nx  = daddr_q;
        caddr_nx  = caddr_q;
        remain_nx = remain_q;
        vid_nx    = vid_q;
        rd_en_nx  = rd_en_q;
        clr_nx    = clr_q;
        last_nx   = last_q;
        busy_nx   = busy_q;
        done_nx   = done_q;
        err_nx    = err_q;

        if (!bus.hold) begin
            done_nx = 1'b0;
            err_nx  = 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        if (start_ok) begin
                            lptr_nx   = bus.data_lptr;
                            uptr_nx   = bus.data_uptr;
                            daddr_nx  = bus.data_head;
                            caddr_nx  = bus.coef_ptr;
                            vid_nx    = bus.vector_id;
                            remain_nx = {1'b0, bus.data_uptr} - {1'b0, bus.data_lptr} + CW'(1);
                            rd_en_nx  = 1'b1;
                            clr_nx    = 1'b1;
                            last_nx   = (bus.data_lptr == bus.data_uptr);
                            busy_nx   = 1'b1;
                            state_nx  = S_RUN;
                        end else begin
                            err_nx = 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    if (remain_q == CW'(1)) begin
                        rd_en_nx = 1'b0;
                        clr_nx   = 1'b0;
                        last_nx  = 1'b0;
                        done_nx  = 1'b1;
                        state_nx = S_DONE;
                    end else begin
                        // Data walks backwards from the newest sample, wrapping at the lower bound.
                        daddr_nx  = (daddr_q == lptr_q) ? uptr_q : daddr_q - DAWIDTH'(1);
                        caddr_nx  = caddr_q + DAWIDTH'(1);
                        remain_nx = remain_q - CW'(1);
                        clr_nx    = 1'b0;
                        last_nx   = (remain_q == CW'(2));
                    end
                end
                S_DONE: begin
                    busy_nx  = 1'b0;
                    state_nx = S_IDLE;
                end
                default: state_nx = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lptr_q   <= '0;
            uptr_q   <= '0;
            daddr_q  <= '0;
            caddr_q  <= '0;
            remain_q <= '0;
            vid_q    <= '0;
            rd_en_q  <= 1'b0;
            clr_q    <= 1'b0;
            last_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            lptr_q   <= lptr_nx;
            uptr_q   <= uptr_nx;
            daddr_q  <= daddr_nx;
            caddr_q  <= caddr_nx;
            remain_q <= remain_nx;
            vid_q    <= vid_nx;
            rd_en_q  <= rd_en_nx;
            clr_q    <= clr_nx;
            last_q   <= last_nx;
            busy_q   <= busy_nx;
            done_q   <= done_nx;
            err_q    <= err_nx;
        end
    end

    assign bus.rd_en     = rd_en_q;
    assign bus.data_addr = daddr_q;
    assign bus.coef_addr = caddr_q;
    assign bus.acc_clr   = clr_q;
    assign bus.acc_last  = last_q;
    assign bus.vid_out   = vid_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;
endmodule

// File: tb/tb_tap_addr_gen.sv
// Randomized self-checking bench for tap_addr_gen against a tap-list reference model.
module tb_tap_addr_gen;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    tap_addr_gen_if #(.DAWIDTH(12), .VIDWIDTH(5)) bus ();
    tap_addr_gen_if #(.DAWIDTH(4),  .VIDWIDTH(5)) bus4 ();

    tap_addr_gen #(.DAWIDTH(12), .VIDWIDTH(5)) dut  (.clk(clk), .rst(rst), .bus(bus));
    tap_addr_gen #(.DAWIDTH(4),  .VIDWIDTH(5)) dut4 (.clk(clk), .rst(rst), .bus(bus4));

    // Reference model: phase 0 idle, 1 running tap m_tap of m_n, 2 done pulse.
    int m_phase = 0;
    int m_tap = 0;
    int m_n = 0;
    bit m_err = 1'b0;
    int m_vid = 0;
    int m_data[$];
    int m_coef[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase = 0;
        m_tap   = 0;
        m_err   = 1'b0;
    endtask

    task automatic model_step();
        int lp, up, hd, cp;
        if (bus.hold) return;
        m_err = 1'b0;
        case (m_phase)
            0: if (bus.start) begin
                lp = int'(bus.data_lptr);
                up = int'(bus.data_uptr);
                hd = int'(bus.data_head);
                cp = int'(bus.coef_ptr);
                if (lp <= up && hd >= lp && hd <= up) begin
                    m_n = up - lp + 1;
                    m_data.delete();
                    m_coef.delete();
                    for (int i = 0; i < m_n; i++) begin
                        m_data.push_back(lp + (((hd - lp - i) % m_n) + m_n) % m_n);
                        m_coef.push_back((cp + i) % 4096);
                    end
                    m_vid   = int'(bus.vector_id);
                    m_tap   = 0;
                    m_phase = 1;
                end else begin
                    m_err = 1'b1;
                end
            end
            1: if (m_tap == m_n - 1) m_phase = 2; else m_tap++;
            default: m_phase = 0;
        endcase
    endtask

    task automatic compare_all();
        check("rd_en", bus.rd_en, m_phase == 1);
        check("busy",  bus.busy,  m_phase != 0);
        check("done",  bus.done,  m_phase == 2);
        check("err",   bus.err,   m_err);
        check("acc_clr",  bus.acc_clr,  m_phase == 1 && m_tap == 0);
        check("acc_last", bus.acc_last, m_phase == 1 && m_tap == m_n - 1);
        if (m_phase == 1) begin
            check("data_addr", bus.data_addr, m_data[m_tap]);
            check("coef_addr", bus.coef_addr, m_coef[m_tap]);
            check("vid_out",   bus.vid_out,   m_vid);
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic run_vec(input int lp, input int up, input int hd, input int cp, input int vid,
                           input int hold_pct, input int stall_tap, input int abort_tap);
        int  stall_left = 2;
        bit  finished = 1'b0;
        bus.data_lptr = 12'(lp);
        bus.data_uptr = 12'(up);
        bus.data_head = 12'(hd);
        bus.coef_ptr  = 12'(cp);
        bus.vector_id = 5'(vid);
        bus.hold  = 1'b0;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int c = 0; c < 300; c++) begin
            if ((m_phase == 0 && !m_err) ||
                (abort_tap >= 0 && m_phase == 1 && m_tap == abort_tap)) begin
                finished = 1'b1;
                break;
            end
            bus.hold = ($urandom_range(99) < hold_pct);
            if (m_phase == 1 && m_tap == stall_tap && stall_left > 0) begin
                bus.hold = 1'b1;
                stall_left--;
            end
            bus.data_lptr = 12'($urandom);
            bus.data_uptr = 12'($urandom);
            bus.data_head = 12'($urandom);
            bus.coef_ptr  = 12'($urandom);
            bus.vector_id = 5'($urandom);
            bus.start = (m_phase != 0) && ($urandom_range(3) == 0);
            tick();
        end
        bus.start = 1'b0;
        bus.hold  = 1'b0;
        check("finish", finished, 1'b1);
    endtask

    task automatic full_range_4();
        bus4.data_lptr = 4'd0;
        bus4.data_uptr = 4'd15;
        bus4.data_head = 4'd0;
        bus4.coef_ptr  = 4'd15;
        bus4.vector_id = 5'd9;
        bus4.start = 1'b1;
        @(posedge clk);
        #1;
        bus4.start = 1'b0;
        for (int i = 0; i < 16; i++) begin
            check("w4_rd_en", bus4.rd_en, 1'b1);
            check("w4_data",  bus4.data_addr, (16 - i) % 16);
            check("w4_coef",  bus4.coef_addr, (15 + i) % 16);
            check("w4_clr",   bus4.acc_clr,  i == 0);
            check("w4_last",  bus4.acc_last, i == 15);
            @(posedge clk);
            #1;
        end
        check("w4_rd_en_off", bus4.rd_en, 1'b0);
        check("w4_done", bus4.done, 1'b1);
        @(posedge clk);
        #1;
        check("w4_done_off", bus4.done, 1'b0);
        check("w4_busy_off", bus4.busy, 1'b0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lp, up, hd, cp;
        bus.start = 1'b0;  bus.hold = 1'b0;
        bus.data_lptr = '0; bus.data_uptr = '0; bus.data_head = '0; bus.coef_ptr = '0;
        bus.vector_id = '0;
        bus4.start = 1'b0; bus4.hold = 1'b0;
        bus4.data_lptr = '0; bus4.data_uptr = '0; bus4.data_head = '0; bus4.coef_ptr = '0;
        bus4.vector_id = '0;
        model_reset();

        repeat (3) @(posedge clk);
        #1;
        compare_all();
        check("rst_data_addr", bus.data_addr, 0);
        check("rst_coef_addr", bus.coef_addr, 0);
        check("rst_vid_out",   bus.vid_out,   0);
        rst = 1'b1;
        tick();

        // Basic walk, single tap, stall at tap 3
        run_vec(16, 23, 19, 100, 3, 0, -1, -1);
        run_vec(5, 5, 5, 0, 1, 0, -1, -1);
        run_vec(16, 23, 19, 100, 4, 0, 3, -1);

        // Rejected starts, and a start dropped under hold
        run_vec(12, 10, 11, 7, 2, 0, -1, -1);
        run_vec(16, 23, 30, 7, 2, 0, -1, -1);
        bus.data_lptr = 12'd16; bus.data_uptr = 12'd23; bus.data_head = 12'd19;
        bus.start = 1'b1; bus.hold = 1'b1;
        tick();
        bus.start = 1'b0; bus.hold = 1'b0;
        tick();

        full_range_4();

        // Reset mid-vector at tap 4
        run_vec(16, 23, 19, 100, 6, 0, -1, 4);
        #2;
        rst = 1'b0;
        #1;
        check("arst_rd_en",     bus.rd_en, 0);
        check("arst_data_addr", bus.data_addr, 0);
        check("arst_coef_addr", bus.coef_addr, 0);
        check("arst_acc_clr",   bus.acc_clr, 0);
        check("arst_acc_last",  bus.acc_last, 0);
        check("arst_vid_out",   bus.vid_out, 0);
        check("arst_busy",      bus.busy, 0);
        check("arst_done",      bus.done, 0);
        check("arst_err",       bus.err, 0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        tick();
        run_vec(16, 23, 19, 100, 7, 0, -1, -1);

        // Random vectors with random holds, late starts and pointer churn
        for (int v = 0; v < 40; v++) begin
            if ($urandom_range(3) == 0) begin
                lp = $urandom_range(0, 4095);
                up = $urandom_range(0, 4095);
                hd = $urandom_range(0, 4095);
            end else begin
                lp = $urandom_range(0, 4000);
                up = lp + $urandom_range(0, 20);
                hd = $urandom_range(lp, up);
            end
            cp = ($urandom_range(1) == 1) ? $urandom_range(4080, 4095) : $urandom_range(0, 4095);
            run_vec(lp, up, hd, cp, $urandom_range(0, 31), 20, -1, -1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
